retire_commit_engine: RTL and testbench

Parametrised N-wide in-order retire engine sitting between the ROB head window and the arch map table, freelist, store queue and fetch redirect. It generalises single-store, combinational-mispredict retirement with several additions:
- a configurable number of stores committed per cycle, granted by the D-cache;
- a registered flush pulse, followed by a RECOVER hold-off state machine;
- a sticky HALTED state;
- registered commit packets for the debug bus.

---
 rtl/retire_commit_engine.sv | 140 ++++++++++++++
 tb/tb_retire_commit_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_commit_engine.sv
// retire_commit_engine: N-wide in-order ROB retirement with store grants, registered flush + RECOVER hold-off, sticky halt.
// Optional RETIRE_PERF_EN adds perf_retired / perf_store_stall / perf_flushes counters.
module retire_commit_engine #(
  parameter int RETIRE_WIDTH   = 4,
  parameter int STORE_PORTS    = 1,
  parameter int PHYS_REGS      = 64,
  parameter int ROB_DEPTH      = 32,
  parameter int RECOVER_CYCLES = 2,
  localparam int PRW = $clog2(PHYS_REGS),
  localparam int RIW = $clog2(ROB_DEPTH),
  localparam int CW  = $clog2(RETIRE_WIDTH + 1),
  localparam int SW  = $clog2(STORE_PORTS + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [RETIRE_WIDTH-1:0]     head_valid,
  input  logic [RETIRE_WIDTH-1:0]     head_complete,
  input  logic [RETIRE_WIDTH-1:0]     head_store,
  input  logic [RETIRE_WIDTH-1:0]     head_mispred,
  input  logic [RETIRE_WIDTH-1:0]     head_halt,
  input  logic [RETIRE_WIDTH-1:0]     head_dest_valid,
  input  logic [RETIRE_WIDTH*PRW-1:0] head_phys_rd,
  input  logic [RETIRE_WIDTH*PRW-1:0] head_prev_phys_rd,
  input  logic [RETIRE_WIDTH*5-1:0]   head_arch_rd,
  input  logic [RETIRE_WIDTH*RIW-1:0] head_rob_idx,
  input  logic [SW-1:0]               st_grant,
  output logic [CW-1:0]               retire_count,
  output logic [SW-1:0]               st_commit_count,
  output logic [RETIRE_WIDTH-1:0]     arch_we,
  output logic [RETIRE_WIDTH*5-1:0]   arch_addr,
  output logic [RETIRE_WIDTH*PRW-1:0] arch_phys,
  output logic [PHYS_REGS-1:0]        free_mask,
  output logic                        flush,
  output logic [RIW-1:0]              flush_rob_idx,
  output logic                        halted,
  output logic [RETIRE_WIDTH-1:0]     commit_valid,
  output logic [RETIRE_WIDTH*5-1:0]   commit_reg
`ifdef RETIRE_PERF_EN
 ,output logic [63:0]                 perf_retired,
  output logic [63:0]                 perf_store_stall,
  output logic [63:0]                 perf_flushes
`endif
);
  typedef enum logic [1:0] {RUN, RECOVER, HALTED} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [SW-1:0] grant, st_cnt;
  logic stop, mis_hit, halt_hit, stall;
  logic [RIW-1:0] mis_idx;
  logic [RETIRE_WIDTH-1:0] commit;
  logic [RETIRE_WIDTH*5-1:0] reg_nx;
  logic [PRW-1:0] prev;
  assign grant = st_grant > SW'(STORE_PORTS) ? SW'(STORE_PORTS) : st_grant;
  assign st_commit_count = st_cnt;
  assign halted = state == HALTED;
  always_comb begin
    retire_count = '0;
    st_cnt = '0;
    arch_we = '0;
    arch_addr = '0;
    arch_phys = '0;
    free_mask = '0;
    commit = '0;
    reg_nx = '0;
    mis_hit = 1'b0;
    halt_hit = 1'b0;
    stall = 1'b0;
    mis_idx = '0;
    prev = '0;
    // gating with reset keeps every output at 0 while reset is held
    stop = reset || state != RUN;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      prev = head_prev_phys_rd[i*PRW +: PRW];
      if (!stop) begin
        if (!head_valid[i] || !head_complete[i]) stop = 1'b1;
        else if (head_store[i] && st_cnt >= grant) begin
          stop = 1'b1;
          stall = 1'b1;
        end else begin
          commit[i] = 1'b1;
          retire_count = retire_count + CW'(1);
          st_cnt = st_cnt + SW'(head_store[i]);
          if (head_dest_valid[i]) begin
            arch_we[i] = 1'b1;
            arch_addr[i*5 +: 5] = head_arch_rd[i*5 +: 5];
            arch_phys[i*PRW +: PRW] = head_phys_rd[i*PRW +: PRW];
            reg_nx[i*5 +: 5] = head_arch_rd[i*5 +: 5];
            if (prev != '0) free_mask[prev] = 1'b1;
          end
          // halt outranks a mispredict in the same slot
          if (head_halt[i]) begin
            halt_hit = 1'b1;
            stop = 1'b1;
          end else if (head_mispred[i]) begin
            mis_hit = 1'b1;
            mis_idx = head_rob_idx[i*RIW +: RIW];
            stop = 1'b1;
          end
        end
      end
    end
    state_nx = state == RUN ? (halt_hit ? HALTED : mis_hit ? RECOVER : RUN) :
               state == RECOVER ? (cnt <= 4'd1 ? RUN : RECOVER) : state;
    cnt_nx = state == RUN ? (mis_hit ? 4'(RECOVER_CYCLES) : cnt) :
             state == RECOVER ? (cnt == 4'd0 ? cnt : cnt - 4'd1) : cnt;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      flush <= 1'b0;
      flush_rob_idx <= '0;
      commit_valid <= '0;
      commit_reg <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      flush <= mis_hit;
      if (mis_hit) flush_rob_idx <= mis_idx;
      commit_valid <= commit;
      commit_reg <= reg_nx;
    end
  end
`ifdef RETIRE_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_retired <= '0;
      perf_store_stall <= '0;
      perf_flushes <= '0;
    end else begin
      perf_retired <= perf_retired + 64'(retire_count);
      perf_store_stall <= perf_store_stall + 64'(stall);
      perf_flushes <= perf_flushes + 64'(flush);
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stall;
`endif
endmodule

// File: tb/tb_retire_commit_engine.sv
// tb_retire_commit_engine: directed + randomized checks of retire_commit_engine against a behavioural model.
module tb_retire_commit_engine;
  localparam int RC = 2;
  logic clock = 1'b0, reset = 1'b1;
  logic [3:0] hv, hc, hs, hm, hh, hd;
  logic [23:0] hp, hpp;
  logic [19:0] ha, hi;
  logic [1:0] st_grant;
  logic [2:0] retire_count;
  logic [1:0] st_commit_count;
  logic [3:0] arch_we, commit_valid;
  logic [19:0] arch_addr, commit_reg;
  logic [23:0] arch_phys;
  logic [63:0] free_mask;
  logic flush, halted;
  logic [4:0] flush_rob_idx;
`ifdef RETIRE_PERF_EN
  logic [63:0] perf_retired, perf_store_stall, perf_flushes;
`endif
  int vectors = 0, errors = 0;
  int e_rc, e_sc, m_rec;
  logic [3:0] e_we, e_cv, r_cv;
  logic [19:0] e_addr, e_cr, r_cr;
  logic [23:0] e_phys;
  logic [63:0] e_free;
  logic e_mis, e_halt, r_flush, m_halted;
  logic [4:0] e_midx, r_fidx;

  retire_commit_engine #(.RETIRE_WIDTH(4), .STORE_PORTS(2), .PHYS_REGS(64), .ROB_DEPTH(32), .RECOVER_CYCLES(RC)) dut (
    .clock(clock), .reset(reset), .head_valid(hv), .head_complete(hc), .head_store(hs), .head_mispred(hm),
    .head_halt(hh), .head_dest_valid(hd), .head_phys_rd(hp), .head_prev_phys_rd(hpp), .head_arch_rd(ha),
    .head_rob_idx(hi), .st_grant(st_grant), .retire_count(retire_count), .st_commit_count(st_commit_count),
    .arch_we(arch_we), .arch_addr(arch_addr), .arch_phys(arch_phys), .free_mask(free_mask), .flush(flush),
    .flush_rob_idx(flush_rob_idx), .halted(halted), .commit_valid(commit_valid), .commit_reg(commit_reg)
`ifdef RETIRE_PERF_EN
   ,.perf_retired(perf_retired), .perf_store_stall(perf_store_stall), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_eval();
    int g;
    bit go;
    g = st_grant > 2 ? 2 : int'(st_grant);
    e_rc = 0; e_sc = 0; e_we = 0; e_addr = 0; e_phys = 0; e_free = 0;
    e_mis = 0; e_halt = 0; e_midx = 0; e_cv = 0; e_cr = 0;
    go = !reset && !m_halted && m_rec == 0;
    for (int i = 0; i < 4; i++) if (go) begin
      if (!hv[i] || !hc[i] || (hs[i] && e_sc >= g)) go = 0;
      else begin
        e_rc++;
        e_cv[i] = 1'b1;
        if (hs[i]) e_sc++;
        if (hd[i]) begin
          e_we[i] = 1'b1;
          e_addr[i*5 +: 5] = ha[i*5 +: 5];
          e_cr[i*5 +: 5] = ha[i*5 +: 5];
          e_phys[i*6 +: 6] = hp[i*6 +: 6];
          if (hpp[i*6 +: 6] != 0) e_free[hpp[i*6 +: 6]] = 1'b1;
        end
        if (hh[i]) begin e_halt = 1; go = 0; end
        else if (hm[i]) begin e_mis = 1; e_midx = hi[i*5 +: 5]; go = 0; end
      end
    end
  endtask

  task automatic model_tick();
    r_flush = e_mis;
    if (e_mis) r_fidx = e_midx;
    r_cv = e_cv;
    r_cr = e_cr;
    if (e_halt) m_halted = 1;
    if (e_mis) m_rec = RC == 0 ? 1 : RC;
    else if (m_rec > 0) m_rec--;
  endtask

  task automatic model_reset();
    r_flush = 0; r_fidx = 0; r_cv = 0; r_cr = 0; m_halted = 0; m_rec = 0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clock);
    model_tick();
    @(negedge clock);
  endtask

  task automatic set_alu();
    hv = 4'hF; hc = 4'hF; hs = 0; hm = 0; hh = 0; hd = 4'hF;
    hp = 24'($urandom); ha = 20'($urandom);
    hpp = {6'd43, 6'd42, 6'd41, 6'd40};
    hi = {5'd3, 5'd2, 5'd1, 5'd0};
    st_grant = 2;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (retire_count !== 0) begin errors++; $display("FAIL reset retire_count got %0d want 0", retire_count); end
    vectors++; if (free_mask !== 0) begin errors++; $display("FAIL reset free_mask got %h want 0", free_mask); end
    vectors++; if (arch_we !== 0) begin errors++; $display("FAIL reset arch_we got %b want 0", arch_we); end
    vectors++; if ({flush, halted, commit_valid} !== 0) begin errors++; $display("FAIL reset regs got flush=%b halted=%b cv=%b want 0", flush, halted, commit_valid); end
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic test_alu4();
    set_alu();
    #1;
    vectors++; if (retire_count !== 3'd4) begin errors++; $display("FAIL alu4 retire_count got %0d want 4", retire_count); end
    vectors++; if (free_mask !== 64'h0000_0F00_0000_0000) begin errors++; $display("FAIL alu4 free_mask got %h want 00000f0000000000", free_mask); end
    vectors++; if (arch_we !== 4'hF || arch_addr !== ha || arch_phys !== hp) begin errors++; $display("FAIL alu4 arch got we=%b addr=%h phys=%h want 1111 %h %h", arch_we, arch_addr, arch_phys, ha, hp); end
    tick();
    #1;
    vectors++; if (commit_valid !== 4'hF) begin errors++; $display("FAIL alu4 commit_valid got %b want 1111", commit_valid); end
    vectors++; if (commit_reg !== ha) begin errors++; $display("FAIL alu4 commit_reg got %h want %h", commit_reg, ha); end
    tick();
  endtask

  task automatic test_store_grant();
    set_alu();
    hs = 4'b0110;
    st_grant = 1;
    #1;
    vectors++; if (retire_count !== 3'd2 || st_commit_count !== 2'd1) begin errors++; $display("FAIL grant1 got rc=%0d sc=%0d want 2 1", retire_count, st_commit_count); end
    st_grant = 2;
    #1;
    vectors++; if (retire_count !== 3'd4 || st_commit_count !== 2'd2) begin errors++; $display("FAIL grant2 got rc=%0d sc=%0d want 4 2", retire_count, st_commit_count); end
    st_grant = 3;
    #1;
    vectors++; if (retire_count !== 3'd4 || st_commit_count !== 2'd2) begin errors++; $display("FAIL grant3_clamp got rc=%0d sc=%0d want 4 2", retire_count, st_commit_count); end
    st_grant = 0;
    #1;
    vectors++; if (retire_count !== 3'd1 || st_commit_count !== 2'd0) begin errors++; $display("FAIL grant0 got rc=%0d sc=%0d want 1 0", retire_count, st_commit_count); end
    tick();
  endtask

  task automatic test_incomplete();
    set_alu();
    hc = 4'b1110;
    #1;
    vectors++; if (retire_count !== 0 || arch_we !== 0 || free_mask !== 0) begin errors++; $display("FAIL incomplete got rc=%0d we=%b free=%h want 0", retire_count, arch_we, free_mask); end
    tick();
    #1;
    vectors++; if (commit_valid !== 0) begin errors++; $display("FAIL incomplete commit_valid got %b want 0", commit_valid); end
    tick();
  endtask

  task automatic test_mispredict();
    set_alu();
    hm = 4'b0010;
    hi = {5'd3, 5'd2, 5'd7, 5'd0};
    #1;
    vectors++; if (retire_count !== 3'd2) begin errors++; $display("FAIL mispred retire_count got %0d want 2", retire_count); end
    tick();
    hm = 0;
    #1;
    vectors++; if (flush !== 1'b1 || flush_rob_idx !== 5'd7) begin errors++; $display("FAIL mispred flush got %b idx=%0d want 1 7", flush, flush_rob_idx); end
    vectors++; if (retire_count !== 0) begin errors++; $display("FAIL recover1 retire_count got %0d want 0", retire_count); end
    tick();
    #1;
    vectors++; if (flush !== 0 || retire_count !== 0) begin errors++; $display("FAIL recover2 got flush=%b rc=%0d want 0 0", flush, retire_count); end
    tick();
    #1;
    vectors++; if (flush !== 0 || retire_count !== 3'd4) begin errors++; $display("FAIL resume got flush=%b rc=%0d want 0 4", flush, retire_count); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      hv = 4'($urandom | $urandom); hc = 4'($urandom | $urandom);
      hs = 4'($urandom & $urandom); hm = 4'($urandom & $urandom & $urandom);
      hh = 0; hd = 4'($urandom);
      hp = 24'($urandom); ha = 20'($urandom); hi = 20'($urandom);
      for (int i = 0; i < 4; i++) hpp[i*6 +: 6] = n[0] ? 6'($urandom_range(0, 7)) : 6'($urandom);
      st_grant = 2'($urandom_range(0, 3));
      #1;
      model_eval();
      vectors++; if (retire_count !== 3'(e_rc)) begin errors++; $display("FAIL rand rc got %0d want %0d", retire_count, e_rc); end
      vectors++; if (st_commit_count !== 2'(e_sc)) begin errors++; $display("FAIL rand sc got %0d want %0d", st_commit_count, e_sc); end
      vectors++; if (arch_we !== e_we || arch_addr !== e_addr || arch_phys !== e_phys) begin errors++; $display("FAIL rand arch got %b %h %h want %b %h %h", arch_we, arch_addr, arch_phys, e_we, e_addr, e_phys); end
      vectors++; if (free_mask !== e_free) begin errors++; $display("FAIL rand free_mask got %h want %h", free_mask, e_free); end
      vectors++; if (flush !== r_flush || (r_flush && flush_rob_idx !== r_fidx)) begin errors++; $display("FAIL rand flush got %b/%0d want %b/%0d", flush, flush_rob_idx, r_flush, r_fidx); end
      vectors++; if (commit_valid !== r_cv || commit_reg !== r_cr || halted !== m_halted) begin errors++; $display("FAIL rand commit got %b %h h=%b want %b %h h=%b", commit_valid, commit_reg, halted, r_cv, r_cr, m_halted); end
      tick();
    end
  endtask

  task automatic test_reset_recover();
    hv = 0;
    repeat (4) tick();
    set_alu();
    hm = 4'b0001;
    #1;
    tick();
    hm = 0;
    reset = 1;
    #1;
    vectors++; if (retire_count !== 0 || st_commit_count !== 0 || arch_we !== 0 || free_mask !== 0) begin errors++; $display("FAIL rst_rec comb got rc=%0d sc=%0d we=%b free=%h want 0", retire_count, st_commit_count, arch_we, free_mask); end
    vectors++; if ({flush, halted, commit_valid, commit_reg} !== 0) begin errors++; $display("FAIL rst_rec regs got flush=%b halted=%b cv=%b cr=%h want 0", flush, halted, commit_valid, commit_reg); end
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    #1;
    vectors++; if (retire_count !== 3'd4 || flush !== 0) begin errors++; $display("FAIL rst_rec run got rc=%0d flush=%b want 4 0", retire_count, flush); end
    tick();
    #1;
    vectors++; if (flush !== 0 || commit_valid !== 4'hF) begin errors++; $display("FAIL rst_rec after got flush=%b cv=%b want 0 1111", flush, commit_valid); end
  endtask

  task automatic test_halt();
    set_alu();
    hh = 4'b0100;
    hm = 4'b0100;
    #1;
    vectors++; if (retire_count !== 3'd3) begin errors++; $display("FAIL halt retire_count got %0d want 3", retire_count); end
    tick();
    hh = 0;
    hm = 0;
    #1;
    vectors++; if (halted !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL halt got halted=%b flush=%b want 1 0", halted, flush); end
    vectors++; if (commit_valid !== 4'b0111) begin errors++; $display("FAIL halt commit_valid got %b want 0111", commit_valid); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (retire_count !== 0 || halted !== 1'b1) begin errors++; $display("FAIL halted_hold%0d got rc=%0d halted=%b want 0 1", k, retire_count, halted); end
      tick();
      #1;
    end
  endtask

  initial begin
    set_alu();
    model_reset();
    test_reset();
    test_alu4();
    test_store_grant();
    test_incomplete();
    test_mispredict();
    test_random();
    test_reset_recover();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
